// File: rtl/cpu_defs.sv
// Shared pipeline-control definitions: stall encodings, stage bit positions
// and the multi-cycle EX sequencer state type.
package cpu_defs;

  localparam int unsigned STALL_W = 6;

  localparam int unsigned STG_PC    = 0;
  localparam int unsigned STG_IFID  = 1;
  localparam int unsigned STG_IDEX  = 2;
  localparam int unsigned STG_EXMEM = 3;
  localparam int unsigned STG_MEMWB = 4;
  localparam int unsigned STG_RSVD  = 5;

  typedef logic [STALL_W-1:0] stall_t;

  localparam stall_t STALL_NONE = '0;
  // ID hazard freezes PC, IF/ID and ID/EX; EX op additionally freezes EX/MEM.
  localparam stall_t STALL_ID = stall_t'((32'd1 << STG_PC) | (32'd1 << STG_IFID) |
                                         (32'd1 << STG_IDEX));
  localparam stall_t STALL_EX = stall_t'((32'd1 << STG_PC) | (32'd1 << STG_IFID) |
                                         (32'd1 << STG_IDEX) | (32'd1 << STG_EXMEM));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/sat_counter.sv
// Free-running saturating up-counter used for pipeline performance statistics.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: multi-cycle EX sequencing, ID load-use
// stalls, flush handling and a saturating stall-cycle counter.
module stall_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stallreq,
  input  logic              ex_start,
  input  logic [CNT_W-1:0]  ex_cycles,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              ex_busy,
  output logic              ex_done,
  output logic              ex_cancel,
  output logic [PERF_W-1:0] stall_cycles
);

  ex_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_ok;
  logic             ex_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and combinational hold/flush outputs; priority flush > EX > ID.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = STALL_NONE;
    flush     = 1'b0;
    ex_busy   = 1'b0;
    ex_done   = 1'b0;
    ex_cancel = 1'b0;
    start_ok  = (state_q == ST_IDLE) && ex_start && (ex_cycles >= CNT_W'(2));
    ex_stall  = start_ok || (state_q == ST_BUSY);

    case (state_q)
      ST_IDLE: begin
        if (ex_start && (ex_cycles >= CNT_W'(3))) begin
          state_d = ST_BUSY;
          cnt_d   = ex_cycles - CNT_W'(2);
        end else if (ex_start && (ex_cycles == CNT_W'(2))) begin
          state_d = ST_DONE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Reset silences every output; the register process handles the state.
    if (!rst) begin
      ex_busy = (state_q == ST_BUSY);
      if (flush_req) begin
        flush     = 1'b1;
        ex_cancel = (state_q == ST_BUSY) || (state_q == ST_DONE);
        state_d   = ST_IDLE;
        cnt_d     = '0;
      end else begin
        ex_done = (state_q == ST_DONE);
        if (ex_stall) begin
          stall = STALL_EX;
        end else if (id_stallreq) begin
          stall = STALL_ID;
        end
      end
    end
  end

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall[STG_PC]),
    .count_o (stall_cycles)
  );

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: cycle-indexed reference model plus
// directed scenarios with literal expectations.
module tb_stall_ctrl;

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PERF_W = 5;
  localparam longint      PERF_MAX = (64'd1 << PERF_W) - 1;

  logic              clk;
  logic              rst;
  logic              id_stallreq;
  logic              ex_start;
  logic [CNT_W-1:0]  ex_cycles;
  logic              flush_req;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_busy;
  logic              ex_done;
  logic              ex_cancel;
  logic [PERF_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_stallreq  (id_stallreq),
    .ex_start     (ex_start),
    .ex_cycles    (ex_cycles),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .ex_busy      (ex_busy),
    .ex_done      (ex_done),
    .ex_cancel    (ex_cancel),
    .stall_cycles (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: an accepted op of N cycles starting at cycle t0 stalls
  // t0..t0+N-2, is busy t0+1..t0+N-2 and completes at t0+N-1.
  int     cyc = 0;
  bit     op_act = 1'b0;
  int     op_t0 = 0;
  int     op_n = 0;
  longint perf = 0;
  bit     perf_known = 1'b0;
  bit     in_ex, busy_e, done_e, acc, flush_e, cancel_e;
  logic [5:0] st_e;

  always @(negedge clk) begin
    if (rst) begin
      chk("m_stall", 64'(stall), 64'h0);
      chk("m_flush", 64'(flush), 64'h0);
      chk("m_busy", 64'(ex_busy), 64'h0);
      chk("m_done", 64'(ex_done), 64'h0);
      chk("m_cancel", 64'(ex_cancel), 64'h0);
      if (perf_known) chk("m_stall_cycles", 64'(stall_cycles), 64'(perf));
      op_act     = 1'b0;
      perf       = 0;
      perf_known = 1'b1;
    end else begin
      in_ex  = op_act && (cyc > op_t0) && (cyc <= op_t0 + op_n - 1);
      busy_e = op_act && (cyc > op_t0) && (cyc <= op_t0 + op_n - 2);
      done_e = op_act && (cyc == op_t0 + op_n - 1);
      acc    = !in_ex && ex_start && (int'(ex_cycles) >= 2);
      cancel_e = 1'b0;
      flush_e  = flush_req;
      if (flush_req) begin
        st_e     = 6'h00;
        cancel_e = in_ex;
        done_e   = 1'b0;
        op_act   = 1'b0;
      end else begin
        st_e = (acc || busy_e) ? 6'h0F : (id_stallreq ? 6'h07 : 6'h00);
        if (acc) begin
          op_act = 1'b1;
          op_t0  = cyc;
          op_n   = int'(ex_cycles);
        end else if (done_e) begin
          op_act = 1'b0;
        end
      end
      chk("m_stall", 64'(stall), 64'(st_e));
      chk("m_flush", 64'(flush), 64'(flush_e));
      chk("m_busy", 64'(ex_busy), 64'(busy_e));
      chk("m_done", 64'(ex_done), 64'(done_e));
      chk("m_cancel", 64'(ex_cancel), 64'(cancel_e));
      if (perf_known) begin
        chk("m_stall_cycles", 64'(stall_cycles), 64'(perf));
        if (st_e[0] && perf < PERF_MAX) perf++;
      end
    end
    cyc++;
  end

  task automatic step(input logic r, input logic id, input logic st,
                      input logic [CNT_W-1:0] n, input logic fl);
    @(posedge clk);
    #1;
    rst = r; id_stallreq = id; ex_start = st; ex_cycles = n; flush_req = fl;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; id_stallreq = 1'b0; ex_start = 1'b0; ex_cycles = '0; flush_req = 1'b0;

    step(1, 1, 1, 6'd5, 1);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_flush", 64'(flush), 64'h0);
    step(0, 0, 0, 6'd0, 0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'h0);
    chk("rst_busy", 64'(ex_busy), 64'h0);

    // 5-cycle op, with a start during BUSY that must be ignored
    step(0, 0, 1, 6'd5, 0); chk("op5_t0_stall", 64'(stall), 64'h0F);
    chk("op5_t0_busy", 64'(ex_busy), 64'h0);
    step(0, 0, 0, 6'd0, 0); chk("op5_t1_busy", 64'(ex_busy), 64'h1);
    step(0, 0, 1, 6'd3, 0); chk("op5_t2_stall", 64'(stall), 64'h0F);
    step(0, 0, 0, 6'd0, 0); chk("op5_t3_stall", 64'(stall), 64'h0F);
    step(0, 0, 0, 6'd0, 0); chk("op5_t4_done", 64'(ex_done), 64'h1);
    chk("op5_t4_stall", 64'(stall), 64'h0);
    step(0, 0, 0, 6'd0, 0); chk("op5_t5_busy", 64'(ex_busy), 64'h0);
    chk("op5_t5_done", 64'(ex_done), 64'h0);
    chk("op5_stall_cycles", 64'(stall_cycles), 64'h4);

    // 2-cycle and 1/0-cycle ops
    step(0, 0, 1, 6'd2, 0); chk("op2_t0_stall", 64'(stall), 64'h0F);
    step(0, 0, 0, 6'd0, 0); chk("op2_t1_done", 64'(ex_done), 64'h1);
    chk("op2_t1_stall", 64'(stall), 64'h0);
    step(0, 0, 1, 6'd1, 0); chk("op1_stall", 64'(stall), 64'h0);
    step(0, 0, 0, 6'd0, 0); chk("op1_done", 64'(ex_done), 64'h0);
    step(0, 0, 1, 6'd0, 0); chk("op0_stall", 64'(stall), 64'h0);

    // ID request overlapping BUSY then DONE
    step(0, 1, 1, 6'd5, 0); chk("id_t0_stall", 64'(stall), 64'h0F);
    repeat (3) begin
      step(0, 1, 0, 6'd0, 0); chk("id_busy_stall", 64'(stall), 64'h0F);
    end
    step(0, 1, 0, 6'd0, 0); chk("id_done_stall", 64'(stall), 64'h07);
    chk("id_done_done", 64'(ex_done), 64'h1);
    step(0, 1, 0, 6'd0, 0); chk("id_idle_stall", 64'(stall), 64'h07);

    // Flush on the second BUSY cycle of an 8-cycle op
    step(0, 0, 1, 6'd8, 0);
    step(0, 0, 0, 6'd0, 0);
    step(0, 0, 0, 6'd0, 1); chk("fl_flush", 64'(flush), 64'h1);
    chk("fl_stall", 64'(stall), 64'h0);
    chk("fl_cancel", 64'(ex_cancel), 64'h1);
    step(0, 0, 0, 6'd0, 0); chk("fl_next_busy", 64'(ex_busy), 64'h0);
    repeat (8) begin
      step(0, 0, 0, 6'd0, 0); chk("fl_no_done", 64'(ex_done), 64'h0);
    end

    // Flush coincident with an accepting start
    step(0, 0, 1, 6'd5, 1); chk("flst_stall", 64'(stall), 64'h0);
    chk("flst_cancel", 64'(ex_cancel), 64'h0);
    step(0, 0, 0, 6'd0, 0); chk("flst_busy", 64'(ex_busy), 64'h0);

    // Flush in DONE overrides ex_done and ID request
    step(0, 0, 1, 6'd2, 0);
    step(0, 1, 0, 6'd0, 1); chk("fldone_done", 64'(ex_done), 64'h0);
    chk("fldone_cancel", 64'(ex_cancel), 64'h1);
    chk("fldone_stall", 64'(stall), 64'h0);
    step(0, 0, 0, 6'd0, 0);

    // Reset mid-BUSY, then a normal op after release
    step(0, 0, 1, 6'd8, 0);
    step(0, 0, 0, 6'd0, 0);
    step(1, 1, 1, 6'd5, 1); chk("rb_stall", 64'(stall), 64'h0);
    chk("rb_cancel", 64'(ex_cancel), 64'h0);
    chk("rb_flush", 64'(flush), 64'h0);
    step(0, 0, 1, 6'd3, 0); chk("rb_busy0", 64'(ex_busy), 64'h0);
    chk("rb_stall_new", 64'(stall), 64'h0F);
    step(0, 0, 0, 6'd0, 0); chk("rb_busy1", 64'(ex_busy), 64'h1);
    step(0, 0, 0, 6'd0, 0); chk("rb_done", 64'(ex_done), 64'h1);

    // Counter saturation (5-bit counter: drive to 30, then hold at 31)
    step(1, 0, 0, 6'd0, 0);
    repeat (30) step(0, 1, 0, 6'd0, 0);
    step(0, 1, 0, 6'd0, 0); chk("sat_30", 64'(stall_cycles), 64'd30);
    step(0, 1, 0, 6'd0, 0); chk("sat_31a", 64'(stall_cycles), 64'd31);
    step(0, 1, 0, 6'd0, 0); chk("sat_31b", 64'(stall_cycles), 64'd31);
    step(0, 0, 0, 6'd0, 0); chk("sat_31c", 64'(stall_cycles), 64'd31);

    // Mixed traffic checked by the model only
    step(1, 0, 0, 6'd0, 0);
    for (int i = 0; i < 150; i++) begin
      step(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
           CNT_W'($urandom_range(0, 10)), ($urandom % 12) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
